// File: rtl/aes_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_buffer
// Purpose  : Stream front-end for the AES cores. Ingress deserialises
//            BUS_W-bit bursts into BLK_W-bit blocks queued in a DEPTH-block
//            FIFO; egress serialises result blocks into BUS_W-bit bursts
//            separated by a programmable idle gap.
// Revision : 1.0  initial release
// ============================================================================
module aes_stream_buffer #(
    parameter int BUS_W     = 8,
    parameter int BLK_W     = 128,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int OUT_GAP   = 1
) (
    input  logic                       CLK_I,
    input  logic                       RESET_I,
    input  logic                       CE_I,
    input  logic                       CLR_I,
    input  logic [BUS_W-1:0]           IN_DATA_I,
    input  logic                       IN_VALID_I,
    output logic                       IN_READY_O,
    output logic [BLK_W-1:0]           BLK_DATA_O,
    output logic                       BLK_VALID_O,
    input  logic                       BLK_READY_I,
    input  logic [BLK_W-1:0]           BLK_DATA_I,
    input  logic                       BLK_VALID_I,
    output logic                       BLK_READY_O,
    output logic [BUS_W-1:0]           OUT_DATA_O,
    output logic                       OUT_VALID_O,
    output logic [$clog2(DEPTH+1)-1:0] COUNT_O,
    output logic                       ERR_O
);

    localparam int C_BEATS    = BLK_W / BUS_W;
    localparam int C_BCW      = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam int C_CNT_W    = $clog2(DEPTH + 1);
    localparam int C_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The IDLE cycle in which the next block is accepted is itself one of the
    // low cycles, so the GAP state only has to cover OUT_GAP-1 of them.
    localparam int C_GAP_LOAD = (OUT_GAP > 1) ? (OUT_GAP - 2) : 0;
    localparam int C_GCW      = (C_GAP_LOAD > 0) ? $clog2(C_GAP_LOAD + 1) : 1;

    typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_FILL = 1'b1} in_state_t;
    typedef enum logic [1:0] {EG_IDLE = 2'd0, EG_SEND = 2'd1, EG_GAP = 2'd2} eg_state_t;

    // Physical beat slot for logical beat k, shared by both directions.
    function automatic logic [C_BCW-1:0] slot_of(input logic [C_BCW-1:0] k);
        return (MSB_FIRST != 0) ? (C_BCW'(C_BEATS - 1) - k) : k;
    endfunction

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------ ingress
    in_state_t          in_st_q;
    logic [C_BCW-1:0]   in_beat_q;
    logic [BLK_W-1:0]   asm_q;
    logic [BLK_W-1:0]   mem_q [DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic               in_ready_q;
    logic               err_q;

    logic [C_BCW-1:0]   w_in_idx;
    logic [BLK_W-1:0]   w_asm_merged;
    logic               w_start, w_illegal, w_abort, w_take, w_last, w_fill_nx, w_pop;
    logic [C_CNT_W-1:0] w_cnt_nx, w_count_nx;

    // Decode the ingress handshake and the next FIFO occupancy.
    always_comb begin
        w_in_idx     = (in_st_q == IN_FILL) ? in_beat_q : '0;
        w_asm_merged = asm_q;
        w_asm_merged[slot_of(w_in_idx)*BUS_W +: BUS_W] = IN_DATA_I;
        w_start      = (in_st_q == IN_IDLE) && IN_VALID_I && in_ready_q;
        w_illegal    = (in_st_q == IN_IDLE) && IN_VALID_I && !in_ready_q;
        w_abort      = (in_st_q == IN_FILL) && !IN_VALID_I;
        w_take       = w_start || ((in_st_q == IN_FILL) && IN_VALID_I);
        w_last       = w_take && (w_in_idx == C_BCW'(C_BEATS - 1));
        w_fill_nx    = w_take && !w_last;
        w_pop        = (cnt_q != '0) && BLK_READY_I;
        w_cnt_nx     = cnt_q + C_CNT_W'(w_last) - C_CNT_W'(w_pop);
        w_count_nx   = w_cnt_nx + C_CNT_W'(w_fill_nx);
    end

    // Ingress FSM, FIFO pointers/occupancy, registered ready and sticky error.
    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            in_st_q    <= IN_IDLE;
            in_beat_q  <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (CLR_I) begin
            in_st_q    <= IN_IDLE;
            in_beat_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else if (CE_I) begin
            if (w_take) begin
                asm_q <= w_asm_merged;
            end
            in_st_q   <= w_fill_nx ? IN_FILL : IN_IDLE;
            in_beat_q <= w_fill_nx ? (in_beat_q + 1'b1) : '0;
            if (w_last) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q      <= w_cnt_nx;
            in_ready_q <= (w_count_nx < C_CNT_W'(DEPTH)) && !w_fill_nx;
            if (w_abort || w_illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Block storage; the merged word includes the final beat of the burst.
    always_ff @(posedge CLK_I) begin
        if (CE_I && !CLR_I && !RESET_I && w_last) begin
            mem_q[wr_ptr_q] <= w_asm_merged;
        end
    end

    assign IN_READY_O  = in_ready_q;
    assign BLK_VALID_O = (cnt_q != '0);
    assign BLK_DATA_O  = BLK_VALID_O ? mem_q[rd_ptr_q] : '0;
    assign COUNT_O     = cnt_q + C_CNT_W'(in_st_q == IN_FILL);
    assign ERR_O       = err_q;

    // ------------------------------------------------------------------- egress
    eg_state_t        eg_st_q;
    logic [BLK_W-1:0] obuf_q;
    logic [C_BCW-1:0] ob_idx_q;
    logic [C_GCW-1:0] gap_q;
    logic             out_rdy_q;
    logic             out_valid_q;
    logic [BUS_W-1:0] out_data_q;

    // Egress FSM with registered ready, valid and beat data.
    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            eg_st_q     <= EG_IDLE;
            obuf_q      <= '0;
            ob_idx_q    <= '0;
            gap_q       <= '0;
            out_rdy_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (CLR_I) begin
            eg_st_q     <= EG_IDLE;
            ob_idx_q    <= '0;
            gap_q       <= '0;
            out_rdy_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (CE_I) begin
            case (eg_st_q)
                EG_IDLE: begin
                    if (BLK_VALID_I && out_rdy_q) begin
                        obuf_q      <= BLK_DATA_I;
                        ob_idx_q    <= '0;
                        eg_st_q     <= EG_SEND;
                        out_rdy_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= BLK_DATA_I[slot_of('0)*BUS_W +: BUS_W];
                    end else begin
                        out_rdy_q <= 1'b1;
                    end
                end
                EG_SEND: begin
                    if (ob_idx_q == C_BCW'(C_BEATS - 1)) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        ob_idx_q    <= '0;
                        if (OUT_GAP > 1) begin
                            eg_st_q <= EG_GAP;
                            gap_q   <= C_GCW'(C_GAP_LOAD);
                        end else begin
                            eg_st_q   <= EG_IDLE;
                            out_rdy_q <= 1'b1;
                        end
                    end else begin
                        ob_idx_q   <= ob_idx_q + 1'b1;
                        out_data_q <= obuf_q[slot_of(ob_idx_q + 1'b1)*BUS_W +: BUS_W];
                    end
                end
                EG_GAP: begin
                    if (gap_q == '0) begin
                        eg_st_q   <= EG_IDLE;
                        out_rdy_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    eg_st_q   <= EG_IDLE;
                    out_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign BLK_READY_O = out_rdy_q;
    assign OUT_VALID_O = out_valid_q;
    assign OUT_DATA_O  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stream_buffer
// Purpose  : Directed self-checking bench for aes_stream_buffer using three
//            instances: defaults, 32-bit MSB-first beats, and OUT_GAP=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_stream_buffer;

    logic clk = 1'b0;
    logic rst, ce, clr;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [7:0]   a_in_data;   logic a_in_valid, a_in_ready;
    logic [127:0] a_blk_o;     logic a_blk_valid, a_blk_ready;
    logic [127:0] a_res;       logic a_res_valid, a_res_ready;
    logic [7:0]   a_out;       logic a_out_valid;
    logic [2:0]   a_count;     logic a_err;

    // Instance B: 32-bit beats, MSB first
    logic [31:0]  b_in_data;   logic b_in_valid, b_in_ready;
    logic [127:0] b_blk_o;     logic b_blk_valid, b_blk_ready;
    logic [127:0] b_res;       logic b_res_valid, b_res_ready;
    logic [31:0]  b_out;       logic b_out_valid;
    logic [2:0]   b_count;     logic b_err;

    // Instance C: OUT_GAP = 3
    logic [7:0]   c_in_data;   logic c_in_valid, c_in_ready;
    logic [127:0] c_blk_o;     logic c_blk_valid, c_blk_ready;
    logic [127:0] c_res;       logic c_res_valid, c_res_ready;
    logic [7:0]   c_out;       logic c_out_valid;
    logic [2:0]   c_count;     logic c_err;

    aes_stream_buffer u_a (
        .CLK_I(clk), .RESET_I(rst), .CE_I(ce), .CLR_I(clr),
        .IN_DATA_I(a_in_data), .IN_VALID_I(a_in_valid), .IN_READY_O(a_in_ready),
        .BLK_DATA_O(a_blk_o), .BLK_VALID_O(a_blk_valid), .BLK_READY_I(a_blk_ready),
        .BLK_DATA_I(a_res), .BLK_VALID_I(a_res_valid), .BLK_READY_O(a_res_ready),
        .OUT_DATA_O(a_out), .OUT_VALID_O(a_out_valid), .COUNT_O(a_count), .ERR_O(a_err)
    );

    aes_stream_buffer #(.BUS_W(32), .MSB_FIRST(1)) u_b (
        .CLK_I(clk), .RESET_I(rst), .CE_I(ce), .CLR_I(clr),
        .IN_DATA_I(b_in_data), .IN_VALID_I(b_in_valid), .IN_READY_O(b_in_ready),
        .BLK_DATA_O(b_blk_o), .BLK_VALID_O(b_blk_valid), .BLK_READY_I(b_blk_ready),
        .BLK_DATA_I(b_res), .BLK_VALID_I(b_res_valid), .BLK_READY_O(b_res_ready),
        .OUT_DATA_O(b_out), .OUT_VALID_O(b_out_valid), .COUNT_O(b_count), .ERR_O(b_err)
    );

    aes_stream_buffer #(.OUT_GAP(3)) u_c (
        .CLK_I(clk), .RESET_I(rst), .CE_I(ce), .CLR_I(clr),
        .IN_DATA_I(c_in_data), .IN_VALID_I(c_in_valid), .IN_READY_O(c_in_ready),
        .BLK_DATA_O(c_blk_o), .BLK_VALID_O(c_blk_valid), .BLK_READY_I(c_blk_ready),
        .BLK_DATA_I(c_res), .BLK_VALID_I(c_res_valid), .BLK_READY_O(c_res_ready),
        .OUT_DATA_O(c_out), .OUT_VALID_O(c_out_valid), .COUNT_O(c_count), .ERR_O(c_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block whose byte k (at bits k*8) is base+k
    function automatic logic [127:0] mk8(input logic [7:0] base);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = base + 8'(k);
        return v;
    endfunction

    task automatic push_a(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            a_in_data  = base + 8'(k);
            a_in_valid = 1'b1;
            tick();
        end
        a_in_valid = 1'b0;
        a_in_data  = '0;
    endtask

    logic [31:0]  w4 [4];
    logic [127:0] blk_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        w4[0] = 32'h00112233; w4[1] = 32'h44556677;
        w4[2] = 32'h8899AABB; w4[3] = 32'hCCDDEEFF;
        rst = 1'b1; ce = 1'b1; clr = 1'b0;
        a_in_data = '0; a_in_valid = 0; a_blk_ready = 0; a_res = '0; a_res_valid = 0;
        b_in_data = '0; b_in_valid = 0; b_blk_ready = 0; b_res = '0; b_res_valid = 0;
        c_in_data = '0; c_in_valid = 0; c_blk_ready = 0; c_res = '0; c_res_valid = 0;
        tick(); tick();

        // ---- reset state
        chk("rst_in_ready",  a_in_ready,  0);
        chk("rst_blk_valid", a_blk_valid, 0);
        chk("rst_blk_data",  a_blk_o,     0);
        chk("rst_res_ready", a_res_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data",  a_out,       0);
        chk("rst_count",     a_count,     0);
        chk("rst_err",       a_err,       0);
        rst = 1'b0;
        chk("rel_in_ready_low", a_in_ready, 0);
        tick();
        chk("rel_in_ready",  a_in_ready,  1);
        chk("rel_res_ready", a_res_ready, 1);

        // ---- 1: ingress of bytes 00..0F
        for (int k = 0; k < 16; k++) begin
            a_in_data = 8'(k); a_in_valid = 1'b1;
            tick();
            if (k == 0) begin
                chk("t1_ready_drop", a_in_ready, 0);
                chk("t1_count_fill", a_count,    1);
            end
            if (k == 14) chk("t1_no_valid_early", a_blk_valid, 0);
        end
        a_in_valid = 1'b0;
        chk("t1_blk_valid", a_blk_valid, 1);
        chk("t1_blk_data",  a_blk_o, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t1_count",     a_count, 1);
        chk("t1_ready_back", a_in_ready, 1);
        a_blk_ready = 1'b1; tick(); a_blk_ready = 1'b0;
        chk("t1_pop_valid", a_blk_valid, 0);
        chk("t1_pop_count", a_count, 0);

        // ---- 1: egress of the same block
        a_res = 128'h0F0E0D0C0B0A09080706050403020100; a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t1_out_valid", a_out_valid, 1);
            chk("t1_out_data",  a_out, 8'(k));
            chk("t1_res_busy",  a_res_ready, 0);
            tick();
        end
        chk("t1_out_low",     a_out_valid, 0);
        chk("t1_out_zero",    a_out, 0);
        chk("t1_res_ready_back", a_res_ready, 1);

        // ---- 2: fill FIFO, illegal start, ordered drain
        push_a(8'h10, 16); push_a(8'h20, 16); push_a(8'h30, 16); push_a(8'h40, 16);
        chk("t2_count_full", a_count, 4);
        chk("t2_ready_full", a_in_ready, 0);
        chk("t2_err_before", a_err, 0);
        a_in_valid = 1'b1; a_in_data = 8'hEE; tick(); a_in_valid = 1'b0;
        chk("t2_err_illegal", a_err, 1);
        chk("t2_count_still", a_count, 4);
        chk("t2_head0", a_blk_o, mk8(8'h10));
        a_blk_ready = 1'b1; tick(); a_blk_ready = 1'b0;
        chk("t2_ready_after_pop", a_in_ready, 1);
        chk("t2_count_after_pop", a_count, 3);
        for (int b = 1; b < 4; b++) begin
            chk("t2_head_order", a_blk_o, mk8(8'(16 * (b + 1))));
            a_blk_ready = 1'b1; tick(); a_blk_ready = 1'b0;
        end
        chk("t2_drained", a_count, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t2_clr_err", a_err, 0);
        chk("t2_clr_in_ready", a_in_ready, 1);
        chk("t2_clr_res_ready", a_res_ready, 1);

        // ---- 3: aborted burst
        push_a(8'h50, 16);
        chk("t3_count_prior", a_count, 1);
        for (int k = 0; k < 8; k++) begin
            a_in_data = 8'h90 + 8'(k); a_in_valid = 1'b1; tick();
        end
        chk("t3_count_fill", a_count, 2);
        a_in_valid = 1'b0; tick();
        chk("t3_err", a_err, 1);
        chk("t3_count_restored", a_count, 1);
        chk("t3_ready", a_in_ready, 1);
        chk("t3_head_kept", a_blk_o, mk8(8'h50));
        a_blk_ready = 1'b1; tick(); a_blk_ready = 1'b0;
        chk("t3_no_partial", a_blk_valid, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t3_clr_err", a_err, 0);

        // ---- 4: 32-bit MSB-first ingress and egress
        chk("t4_b_ready", b_in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            b_in_data = w4[k]; b_in_valid = 1'b1; tick();
        end
        b_in_valid = 1'b0;
        chk("t4_b_valid", b_blk_valid, 1);
        chk("t4_b_data", b_blk_o, 128'h00112233445566778899AABBCCDDEEFF);
        b_res = 128'h00112233445566778899AABBCCDDEEFF; b_res_valid = 1'b1; tick(); b_res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_b_out", b_out, w4[k]);
            tick();
        end
        chk("t4_b_out_low", b_out_valid, 0);

        // ---- 5: OUT_GAP=3 with back-to-back result blocks
        chk("t5_c_ready", c_res_ready, 1);
        c_res = mk8(8'hA0); c_res_valid = 1'b1; tick();
        c_res = mk8(8'hC0);
        for (int k = 0; k < 16; k++) begin
            chk("t5_c_burst1", c_out, 8'hA0 + 8'(k));
            chk("t5_c_busy", c_res_ready, 0);
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            chk("t5_c_gap_low", c_out_valid, 0);
            if (g == 2) chk("t5_c_idle_ready", c_res_ready, 1);
            tick();
        end
        c_res_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t5_c_burst2_valid", c_out_valid, 1);
            chk("t5_c_burst2", c_out, 8'hC0 + 8'(k));
            tick();
        end
        chk("t5_c_end_low", c_out_valid, 0);

        // ---- 6: clock-enable freeze mid-burst on both sides
        chk("t6_res_ready", a_res_ready, 1);
        a_res = mk8(8'h70); a_res_valid = 1'b1; tick(); a_res_valid = 1'b0;
        push_a(8'h60, 5);
        chk("t6_out_pre", a_out, 8'h75);
        ce = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t6_frz_count", a_count, 1);
        chk("t6_frz_out",   a_out, 8'h75);
        chk("t6_frz_valid", a_out_valid, 1);
        chk("t6_frz_err",   a_err, 0);
        ce = 1'b1;
        for (int k = 5; k < 16; k++) begin
            chk("t6_out_resume", a_out, 8'h70 + 8'(k));
            a_in_data = 8'h60 + 8'(k); a_in_valid = 1'b1; tick();
        end
        a_in_valid = 1'b0;
        blk_exp = mk8(8'h60);
        chk("t6_blk_intact", a_blk_o, blk_exp);
        chk("t6_out_done", a_out_valid, 0);
        chk("t6_err_clean", a_err, 0);

        // ---- 6: asynchronous reset mid-burst
        a_res = mk8(8'h30); a_res_valid = 1'b1; tick(); a_res_valid = 1'b0;
        push_a(8'h80, 3);
        rst = 1'b1; #2;
        chk("t6_ar_in_ready",  a_in_ready,  0);
        chk("t6_ar_blk_valid", a_blk_valid, 0);
        chk("t6_ar_blk_data",  a_blk_o,     0);
        chk("t6_ar_count",     a_count,     0);
        chk("t6_ar_out_valid", a_out_valid, 0);
        chk("t6_ar_out_data",  a_out,       0);
        chk("t6_ar_res_ready", a_res_ready, 0);
        tick();
        rst = 1'b0; tick();
        chk("t6_rel_in_ready", a_in_ready, 1);
        chk("t6_rel_count",    a_count, 0);
        chk("t6_rel_blk_valid", a_blk_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
